alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, meaning operand/result width.
REQ-002 SHALL have parameter OPW, default 4, meaning ALUOP width.
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-006 SHALL have ports reqN_ready  output  1  requester N accepted this cycle (valid&&ready).
REQ-007 SHALL have ports reqN_porta / reqN_portb  input  DW  operands of requester N.
REQ-008 SHALL have ports reqN_aluop  input  OPW  opcode of requester N.
REQ-009 SHALL have ports rspN_valid  output  1  result for requester N available.
REQ-010 SHALL have ports rspN_ready  input  1  requester N consumes result.
REQ-011 SHALL have port rsp_out  output  DW  result, shared by both requesters.
REQ-012 SHALL have port rsp_flags  output  3  {negative, overflow, zero} captured with rsp_out.
REQ-013 SHALL have ports alu_porta / alu_portb  output  DW  and alu_aluop  output  OPW  driving the shared ALU.
REQ-014 SHALL have ports alu_out  input  DW  and alu_negative / alu_overflow / alu_zero  input  1  from the ALU.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 IDLE: if any reqN_valid, SHALL assert reqN_ready for exactly one winner, combinationally in that cycle; loser ready stays 0.
REQ-017 On accept SHALL register winner porta, portb, aluop and owner id, then go to EXEC.
REQ-018 alu_porta/portb/aluop SHALL always be driven from the operand registers, never combinationally from requester inputs.
REQ-019 EXEC: SHALL capture alu_out and the three flags into result registers, go to RESP; EXEC lasts exactly one cycle.
REQ-020 RESP: SHALL assert rspN_valid only for owner; rsp_out/rsp_flags SHALL stay stable while rspN_valid is high.
REQ-021 RESP with owner rspN_ready=1: SHALL go to IDLE; rspN_valid drops next cycle; rspN_ready of non-owner ignored.
REQ-022 Latency: accept in cycle T -> rspN_valid high in T+2; max throughput one op per 3 cycles.
REQ-023 reqN_ready SHALL be 0 in EXEC and RESP; requester inputs ignored there.
REQ-024 Simultaneous valid in IDLE: winner chosen per REQ-031/032; loser held off until next IDLE.
REQ-025 rsp_flags SHALL pass ALU flags unmodified, including overflow for non-arithmetic opcodes.

Reset
REQ-026 RST high at a rising edge SHALL force IDLE regardless of state, including mid-EXEC/RESP; in-flight result discarded, no response issued.
REQ-027 Reset values: operand regs 0, aluop 0, result regs 0, flags 0, owner 0, rr pointer = 1 (requester 0 wins first tie).
REQ-028 While RST high and cycle after: all reqN_ready and rspN_valid SHALL be 0.
REQ-029 reqN_valid held through reset SHALL be accepted in the first IDLE cycle after RST deasserts.

Configuration
REQ-030 Macro ALU_ARBITER_RR_EN SHALL select tie-break policy.
REQ-031 Defined: round-robin; pointer holds last accepted id, updated only on accept; tie goes to requester != pointer.
REQ-032 Undefined: fixed priority, requester 0 always wins ties; pointer register not implemented.

Verification
REQ-033 req0 ADD porta=5 portb=7 accepted T -> rsp0_valid at T+2, rsp_out=12, rsp_flags=000.
REQ-034 req1 SUB porta=3 portb=3 -> rsp1_valid, rsp_out=0, flags zero=1; rsp0_valid stays 0.
REQ-035 Both valid continuously, ready always 1, ALU_ARBITER_RR_EN defined -> grants 0,1,0,1 every 3 cycles; undefined -> grants 0,0,0.
REQ-036 RESP with rsp0_ready=0 for 5 cycles, ALU inputs changed -> rsp_out/rsp_flags constant, FSM stays RESP, req1_ready=0.
REQ-037 ADD 0x7FFFFFFF+1 -> rsp_out=0x80000000, flags negative=1 overflow=1 zero=0.
REQ-038 RST asserted in EXEC -> next cycle IDLE, no rspN_valid pulse, next request's rsp_out from new operands.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle between two ALU requesters, the arbiter and the shared ALU.
// Handshake rule for every valid/ready pair: a transfer happens in a cycle where both are high; valid never waits on ready.
interface alu_arbiter_if #(
  parameter int DW  = 32,
  parameter int OPW = 4
);
  logic           req0_valid;
  logic           req0_ready;
  logic [DW-1:0]  req0_porta;
  logic [DW-1:0]  req0_portb;
  logic [OPW-1:0] req0_aluop;
  logic           req1_valid;
  logic           req1_ready;
  logic [DW-1:0]  req1_porta;
  logic [DW-1:0]  req1_portb;
  logic [OPW-1:0] req1_aluop;
  logic           rsp0_valid;
  logic           rsp0_ready;
  logic           rsp1_valid;
  logic           rsp1_ready;
  logic [DW-1:0]  rsp_out;
  logic [2:0]     rsp_flags;
  logic [DW-1:0]  alu_porta;
  logic [DW-1:0]  alu_portb;
  logic [OPW-1:0] alu_aluop;
  logic [DW-1:0]  alu_out;
  logic           alu_negative;
  logic           alu_overflow;
  logic           alu_zero;

  modport slave (
    input  req0_valid, req0_porta, req0_portb, req0_aluop,
    input  req1_valid, req1_porta, req1_portb, req1_aluop,
    input  rsp0_ready, rsp1_ready,
    input  alu_out, alu_negative, alu_overflow, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_out, rsp_flags, alu_porta, alu_portb, alu_aluop
  );

  modport master (
    output req0_valid, req0_porta, req0_portb, req0_aluop,
    output req1_valid, req1_porta, req1_portb, req1_aluop,
    output rsp0_ready, rsp1_ready,
    output alu_out, alu_negative, alu_overflow, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_out, rsp_flags, alu_porta, alu_portb, alu_aluop
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: IDLE accepts one op, EXEC captures the ALU result, RESP holds it for the owner.
// Define ALU_ARBITER_RR_EN for round-robin tie-break; otherwise requester 0 wins ties.
module alu_arbiter #(
  parameter int DW  = 32,
  parameter int OPW = 4
) (
  input  logic           CLK,
  input  logic           RST,
  alu_arbiter_if.slave   bus,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [DW-1:0]  opa_q, opb_q, res_q;
  logic [OPW-1:0] op_q;
  logic [2:0]     flg_q;
  logic           owner_q;
  logic           tie_win, win, accept, owner_ready;

`ifdef ALU_ARBITER_RR_EN
  logic ptr_q;
  // Pointer remembers the last winner, so a tie goes to the other side.
  always_comb tie_win = ~ptr_q;

  always_ff @(posedge CLK) begin
    if (RST)         ptr_q <= 1'b1;
    else if (accept) ptr_q <= win;
  end
`else
  always_comb tie_win = 1'b0;
`endif

  always_comb begin
    win         = (bus.req0_valid && bus.req1_valid) ? tie_win : bus.req1_valid;
    accept      = (state == IDLE) && !RST && (bus.req0_valid || bus.req1_valid);
    owner_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (owner_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      owner_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        opa_q   <= win ? bus.req1_porta : bus.req0_porta;
        opb_q   <= win ? bus.req1_portb : bus.req0_portb;
        op_q    <= win ? bus.req1_aluop : bus.req0_aluop;
        owner_q <= win;
      end
      if (state == EXEC) begin
        res_q <= bus.alu_out;
        flg_q <= {bus.alu_negative, bus.alu_overflow, bus.alu_zero};
      end
    end
  end

  // Outputs are masked during reset so nothing is granted or answered while RST is high.
  always_comb begin
    bus.req0_ready = accept && !win;
    bus.req1_ready = accept && win;
    bus.rsp0_valid = (state == RESP) && !RST && !owner_q;
    bus.rsp1_valid = (state == RESP) && !RST && owner_q;
    bus.rsp_out    = res_q;
    bus.rsp_flags  = flg_q;
    bus.alu_porta  = opa_q;
    bus.alu_portb  = opb_q;
    bus.alu_aluop  = op_q;
    state_dbg      = state;
  end

endmodule
